// File: rtl/misaligned_mem_ctrl.sv
// Load/store sequencer: splits word-spanning accesses into two aligned BRAM accesses,
// merges and extends load data, and lane-shifts store data with byte enables.
module misaligned_mem_ctrl #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, RESP, ERR} state_t;

    state_t          state, state_next;
    logic            we_q;
    logic [2:0]      func3_q;
    logic [DW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   lo_q;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we) return (f3 > 3'd2);
        return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    // Access crosses into the next word when offset + size exceeds 4 bytes.
    function automatic logic is_span(input logic [1:0] sz, input logic [1:0] off);
        logic [2:0] size;
        case (sz)
            2'd0:    size = 3'd1;
            2'd1:    size = 3'd2;
            default: size = 3'd4;
        endcase
        return ((3'({1'b0, off}) + size) > 3'd4);
    endfunction

    logic [1:0]    off;
    logic          span_q;
    logic [3:0]    mask;
    logic [3:0]    lo_we, hi_we;
    logic [DW-1:0] lo_din, hi_din;
    logic [DW-1:0] word_addr;
    logic [63:0]   merged;
    logic [DW-1:0] shifted;
    logic [DW-1:0] load_ext;

    assign off       = addr_q[1:0];
    assign span_q    = is_span(func3_q[1:0], off);
    assign mask      = (func3_q[1:0] == 2'd0) ? 4'b0001 :
                       (func3_q[1:0] == 2'd1) ? 4'b0011 : 4'b1111;
    assign lo_we     = 4'(8'(mask) << off);
    assign hi_we     = mask >> (3'd4 - 3'(off));
    assign lo_din    = wdata_q << {off, 3'b000};
    assign hi_din    = wdata_q >> (6'd32 - 6'({off, 3'b000}));
    assign word_addr = {addr_q[31:2], 2'b00};
    assign merged    = span_q ? {mem_dout, lo_q} : {32'b0, mem_dout};
    assign shifted   = 32'(merged >> {off, 3'b000});

    always_comb begin
        case (func3_q)
            3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_ext = {24'b0, shifted[7:0]};
            3'd5:    load_ext = {16'b0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // State and request registers; request is held so the requester may move on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            func3_q <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                func3_q <= req_func3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == ACC_HI) lo_q <= mem_dout;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 4'b0000;
        mem_addr   = '0;
        mem_din    = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (is_illegal(req_we, req_func3) ||
                        (!ALLOW_MISALIGNED && is_span(req_func3[1:0], req_addr[1:0])))
                        state_next = ERR;
                    else
                        state_next = ACC_LO;
                end
            end
            ACC_LO: begin
                mem_en   = 1'b1;
                mem_addr = word_addr;
                if (we_q) begin
                    mem_we  = lo_we;
                    mem_din = lo_din;
                end
                state_next = span_q ? ACC_HI : RESP;
            end
            ACC_HI: begin
                mem_en   = 1'b1;
                mem_addr = word_addr + 32'd4;
                if (we_q) begin
                    mem_we  = hi_we;
                    mem_din = hi_din;
                end
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (!we_q) resp_rdata = load_ext;
                state_next = IDLE;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_misaligned_mem_ctrl.sv
// Scoreboard bench for misaligned_mem_ctrl: one splitting instance, one rejecting instance,
// each with its own BRAM model; expected accesses/responses are queued per request.
module tb_misaligned_mem_ctrl;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
    } acc_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;

    logic        a_req_ready, a_mem_en, a_resp_valid, a_resp_err;
    logic [3:0]  a_mem_we;
    logic [31:0] a_mem_addr, a_mem_din, a_mem_dout, a_resp_rdata;
    logic        b_req_ready, b_mem_en, b_resp_valid, b_resp_err;
    logic [3:0]  b_mem_we;
    logic [31:0] b_mem_addr, b_mem_din, b_mem_dout, b_resp_rdata;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];

    acc_t qa_acc[$], qb_acc[$];
    rsp_t qa_rsp[$], qb_rsp[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    misaligned_mem_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(a_req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_din(a_mem_din), .mem_dout(a_mem_dout),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    misaligned_mem_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(b_req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_din(b_mem_din), .mem_dout(b_mem_dout),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    // BRAM models: 1-cycle read latency, byte-enabled writes, address bits [9:2].
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 32'hA500_0000 | 32'(i);
            mem_a[64] <= 32'h4433_2211;
            mem_a[65] <= 32'h8877_6655;
            mem_a[66] <= 32'hCCBB_AA99;
        end else if (a_mem_en) begin
            a_mem_dout <= mem_a[a_mem_addr[9:2]];
            for (int k = 0; k < 4; k++)
                if (a_mem_we[k]) mem_a[a_mem_addr[9:2]][8*k +: 8] <= a_mem_din[8*k +: 8];
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 32'hA500_0000 | 32'(i);
            mem_b[64] <= 32'h4433_2211;
            mem_b[65] <= 32'h8877_6655;
            mem_b[66] <= 32'hCCBB_AA99;
        end else if (b_mem_en) begin
            b_mem_dout <= mem_b[b_mem_addr[9:2]];
            for (int k = 0; k < 4; k++)
                if (b_mem_we[k]) mem_b[b_mem_addr[9:2]][8*k +: 8] <= b_mem_din[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_acc(input bit b, input int c, input logic [31:0] a,
                           input logic [3:0] we, input logic [31:0] d);
        acc_t e;
        e = '{cyc: c, addr: a, we: we, din: d};
        if (b) qb_acc.push_back(e);
        else   qa_acc.push_back(e);
    endtask

    task automatic exp_rsp(input bit b, input int c, input logic [31:0] r, input logic err);
        rsp_t e;
        e = '{cyc: c, rdata: r, err: err};
        if (b) qb_rsp.push_back(e);
        else   qa_rsp.push_back(e);
    endtask

    // Present one request for one cycle; called just after a rising edge.
    task automatic issue(input bit b, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_we    = we;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = wd;
        if (b) begin
            req_valid_b = 1'b1;
            chk("B req_ready at issue", 32'(b_req_ready), 32'd1);
        end else begin
            req_valid_a = 1'b1;
            chk("A req_ready at issue", 32'(a_req_ready), 32'd1);
        end
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_addr    = 32'h5555_5555;
        req_wdata   = 32'h1234_5678;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
        chk("A access queue drained", 32'(qa_acc.size()), 32'd0);
        chk("A response queue drained", 32'(qa_rsp.size()), 32'd0);
        chk("B access queue drained", 32'(qb_acc.size()), 32'd0);
        chk("B response queue drained", 32'(qb_rsp.size()), 32'd0);
    endtask

    // Scoreboard monitors, sampling on the falling edge.
    always @(negedge clk) begin
        acc_t ea;
        rsp_t er;
        if (a_mem_en === 1'b1) begin
            if (qa_acc.size() == 0) chk("A unexpected mem_en", 32'(a_mem_en), 32'd0);
            else begin
                ea = qa_acc.pop_front();
                chk("A access cycle", 32'(cyc), 32'(ea.cyc));
                chk("A mem_addr", a_mem_addr, ea.addr);
                chk("A mem_we", 32'(a_mem_we), 32'(ea.we));
                chk("A mem_din", a_mem_din, ea.din);
            end
        end
        if (a_resp_valid === 1'b1) begin
            if (qa_rsp.size() == 0) chk("A unexpected resp_valid", 32'(a_resp_valid), 32'd0);
            else begin
                er = qa_rsp.pop_front();
                chk("A response cycle", 32'(cyc), 32'(er.cyc));
                chk("A resp_rdata", a_resp_rdata, er.rdata);
                chk("A resp_err", 32'(a_resp_err), 32'(er.err));
            end
        end
    end

    always @(negedge clk) begin
        acc_t eb;
        rsp_t fb;
        if (b_mem_en === 1'b1) begin
            if (qb_acc.size() == 0) chk("B unexpected mem_en", 32'(b_mem_en), 32'd0);
            else begin
                eb = qb_acc.pop_front();
                chk("B access cycle", 32'(cyc), 32'(eb.cyc));
                chk("B mem_addr", b_mem_addr, eb.addr);
                chk("B mem_we", 32'(b_mem_we), 32'(eb.we));
                chk("B mem_din", b_mem_din, eb.din);
            end
        end
        if (b_resp_valid === 1'b1) begin
            if (qb_rsp.size() == 0) chk("B unexpected resp_valid", 32'(b_resp_valid), 32'd0);
            else begin
                fb = qb_rsp.pop_front();
                chk("B response cycle", 32'(cyc), 32'(fb.cyc));
                chk("B resp_rdata", b_resp_rdata, fb.rdata);
                chk("B resp_err", 32'(b_resp_err), 32'(fb.err));
            end
        end
    end

    initial begin
        int c0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        preload = 1'b0;

        chk("reset req_ready", 32'(a_req_ready), 32'd1);
        chk("reset mem_en", 32'(a_mem_en), 32'd0);
        chk("reset mem_we", 32'(a_mem_we), 32'd0);
        chk("reset resp_valid", 32'(a_resp_valid), 32'd0);
        chk("reset resp_err", 32'(a_resp_err), 32'd0);
        chk("reset resp_rdata", a_resp_rdata, 32'd0);

        // LW 0x100, aligned
        c0 = cyc;
        exp_acc(0, c0 + 1, 32'h100, 4'b0000, 32'h0);
        exp_rsp(0, c0 + 2, 32'h4433_2211, 1'b0);
        issue(0, 0, 3'd2, 32'h100, 32'h0);
        drain();

        // LW 0x102, spans two words
        c0 = cyc;
        exp_acc(0, c0 + 1, 32'h100, 4'b0000, 32'h0);
        exp_acc(0, c0 + 2, 32'h104, 4'b0000, 32'h0);
        exp_rsp(0, c0 + 3, 32'h6655_4433, 1'b0);
        issue(0, 0, 3'd2, 32'h102, 32'h0);
        drain();

        // LH 0x107 sign-extended, then LHU 0x107
        c0 = cyc;
        exp_acc(0, c0 + 1, 32'h104, 4'b0000, 32'h0);
        exp_acc(0, c0 + 2, 32'h108, 4'b0000, 32'h0);
        exp_rsp(0, c0 + 3, 32'hFFFF_9988, 1'b0);
        issue(0, 0, 3'd1, 32'h107, 32'h0);
        drain();
        c0 = cyc;
        exp_acc(0, c0 + 1, 32'h104, 4'b0000, 32'h0);
        exp_acc(0, c0 + 2, 32'h108, 4'b0000, 32'h0);
        exp_rsp(0, c0 + 3, 32'h0000_9988, 1'b0);
        issue(0, 0, 3'd5, 32'h107, 32'h0);
        drain();

        // LB 0x106 positive byte, LB 0x107 negative byte
        c0 = cyc;
        exp_acc(0, c0 + 1, 32'h104, 4'b0000, 32'h0);
        exp_rsp(0, c0 + 2, 32'h0000_0077, 1'b0);
        issue(0, 0, 3'd0, 32'h106, 32'h0);
        drain();
        c0 = cyc;
        exp_acc(0, c0 + 1, 32'h104, 4'b0000, 32'h0);
        exp_rsp(0, c0 + 2, 32'hFFFF_FF88, 1'b0);
        issue(0, 0, 3'd0, 32'h107, 32'h0);
        drain();

        // SW 0x101 split store, then read it back across the boundary
        c0 = cyc;
        exp_acc(0, c0 + 1, 32'h100, 4'b1110, 32'hADBE_EF00);
        exp_acc(0, c0 + 2, 32'h104, 4'b0001, 32'h0000_00DE);
        exp_rsp(0, c0 + 3, 32'h0, 1'b0);
        issue(0, 1, 3'd2, 32'h101, 32'hDEAD_BEEF);
        drain();
        c0 = cyc;
        exp_acc(0, c0 + 1, 32'h100, 4'b0000, 32'h0);
        exp_acc(0, c0 + 2, 32'h104, 4'b0000, 32'h0);
        exp_rsp(0, c0 + 3, 32'hDEAD_BEEF, 1'b0);
        issue(0, 0, 3'd2, 32'h101, 32'h0);
        drain();

        // Illegal func3: load 3, store 4
        c0 = cyc;
        exp_rsp(0, c0 + 1, 32'h0, 1'b1);
        issue(0, 0, 3'd3, 32'h100, 32'h0);
        drain();
        c0 = cyc;
        exp_rsp(0, c0 + 1, 32'h0, 1'b1);
        issue(0, 1, 3'd4, 32'h100, 32'hFFFF_FFFF);
        drain();

        // Reset during ACC_HI drops the response
        c0 = cyc;
        exp_acc(0, c0 + 1, 32'h100, 4'b0000, 32'h0);
        exp_acc(0, c0 + 2, 32'h104, 4'b0000, 32'h0);
        issue(0, 0, 3'd2, 32'h102, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("after reset mem_en", 32'(a_mem_en), 32'd0);
        chk("after reset req_ready", 32'(a_req_ready), 32'd1);
        chk("after reset resp_valid", 32'(a_resp_valid), 32'd0);
        drain();

        // Address wrap: second word of 0xFFFFFFFE is 0x0
        c0 = cyc;
        exp_acc(0, c0 + 1, 32'hFFFF_FFFC, 4'b0000, 32'h0);
        exp_acc(0, c0 + 2, 32'h0000_0000, 4'b0000, 32'h0);
        exp_rsp(0, c0 + 3, 32'h0000_A500, 1'b0);
        issue(0, 0, 3'd2, 32'hFFFF_FFFE, 32'h0);
        drain();

        // Misalignment rejected on the non-splitting instance; aligned still works
        c0 = cyc;
        exp_rsp(1, c0 + 1, 32'h0, 1'b1);
        issue(1, 0, 3'd2, 32'h102, 32'h0);
        drain();
        c0 = cyc;
        exp_acc(1, c0 + 1, 32'h100, 4'b0000, 32'h0);
        exp_rsp(1, c0 + 2, 32'h4433_2211, 1'b0);
        issue(1, 0, 3'd2, 32'h100, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/misaligned_mem_ctrl.md
Name: misaligned_mem_ctrl

Overview:
- Load/store sequencer between the core's memory stage and the synchronous data memory (BRAM, 1-cycle read latency).
- Accepts one load/store request at a time and issues one or two aligned word accesses; two are needed when the access spans a word boundary.
- For loads, it merges the returned bytes and sign-/zero-extends them per func3. For stores, it generates the per-word byte enables and lane-shifted write data.

Parameters:
- ALLOW_MISALIGNED, 1: when 0, any word-spanning access is rejected with resp_err instead of being split.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RISC-V funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; stores use SB=0, SH=1, SW=2.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte write enables; all zero for reads.
- mem_addr  out  32  word-aligned address; [1:0] are always 0.
- mem_din  out  32  write data to memory.
- mem_dout  in  32  read data, valid the cycle after a read strobe.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  illegal func3, or misaligned access with ALLOW_MISALIGNED=0; qualified by resp_valid.

Behaviour:
- Reset values: state IDLE; req_ready=1; mem_en=0; mem_we=0; resp_valid=0; resp_err=0; resp_rdata=0; internal registers cleared.
- Clock and reset: clk is the only clock. rst is synchronous and active-high.
- Legal func3: loads 0, 1, 2, 4, 5; stores 0, 1, 2. Any other value is an error.
  - Error responses: no memory access; resp_valid=1 and resp_err=1 in the cycle after acceptance.
- Access size: byte = 1, half = 2, word = 4 bytes. off = addr[1:0].
  - span = (off + size > 4); possible for halfword with off=3 and word with off≠0.
  - A byte access never spans.
- FSM states: IDLE, ACC_LO, ACC_HI, RESP, ERR.
  - IDLE: req_ready=1. When req_valid is high, register the request and go to ERR (illegal, or span with !ALLOW_MISALIGNED) or to ACC_LO.
  - ACC_LO: mem_en=1, mem_addr={addr[31:2],2'b00}. Go to ACC_HI if span, else RESP.
  - ACC_HI: mem_en=1, mem_addr = low word + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x0). Capture mem_dout (the low word) into lo_reg. Go to RESP.
  - RESP: resp_valid=1 for exactly one cycle; return to IDLE. req_ready=0 in this cycle (no back-to-back overlap).
  - ERR: resp_valid=1, resp_err=1; return to IDLE.
- Latency from the acceptance cycle c0:
  - Non-spanning: memory access in c1, resp_valid in c2.
  - Spanning: memory accesses in c1 and c2, resp_valid in c3.
  - Error: resp_valid in c1.
- Store lanes: mask = 0001/0011/1111 by size.
  - Low word: mem_we = (mask<<off)[3:0]; mem_din = wdata<<(8*off).
  - High word: mem_we = mask>>(4-off); mem_din = wdata>>(8*(4-off)).
  - Reads: mem_we=0.
- Load merge: in RESP, form the 64-bit value {mem_dout, lo_reg} if span, else {32'b0, mem_dout}. Shift right by 8*off and take the low 32 bits.
  - Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- resp_rdata is 0 outside RESP and for stores. mem_din is 0 when not writing.
- req_* inputs are ignored while not in IDLE. The request is held internally, so the requester may change its inputs after acceptance.
- Reset asserted in any state: IDLE next cycle. The in-flight response is dropped; no resp_valid, no further mem_en.

Test Plan:
- Memory preload for all scenarios: [0x100]=0x44332211, [0x104]=0x88776655, [0x108]=0xCCBBAA99.
- LW 0x100 -> single read at 0x100 in c1; c2 resp_valid, rdata=0x44332211.
- LW 0x102 -> reads 0x100 (c1) and 0x104 (c2); c3 rdata=0x66554433.
- LH 0x107 -> reads 0x104 and 0x108; rdata=0xFFFF9988. Repeat as LHU 0x107 -> 0x00009988. LB 0x106 -> single read, rdata=0x00000077.
- SW 0x101, wdata=0xDEADBEEF:
  - c1: addr 0x100, we=1110, din=0xADBEEF00.
  - c2: addr 0x104, we=0001, din=0x000000DE.
  - c3: resp_valid, rdata=0.
- Error cases: load with func3=3 -> no mem_en, c1 resp_valid=1, resp_err=1. With ALLOW_MISALIGNED=0, LW 0x102 -> same error response; LW 0x100 still succeeds.
- Reset and wrap:
  - Assert rst in ACC_HI of LW 0x102 -> no resp_valid; next cycle mem_en=0, req_ready=1.
  - LW 0xFFFFFFFE -> second access at mem_addr 0x00000000.
